// File: rtl/glitch_phase_sweep.sv
// Phase-sweep controller for the glitchy-clock generator: steps the DCM phase through a range
// and fires a fixed number of glitch requests per settled point. Ack timeout enabled by GLITCH_SWEEP_TIMEOUT_EN.
module glitch_phase_sweep #(
    parameter int PHASE_W        = 8,
    parameter int SHOTS_W        = 8,
    parameter int SETTLE_CYCLES  = 16,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic               clkin,
    input  logic               rst,
    input  logic               start,
    input  logic               abort,
    input  logic [PHASE_W-1:0] phase_min,
    input  logic [PHASE_W-1:0] phase_max,
    input  logic [PHASE_W-1:0] phase_step,
    input  logic [SHOTS_W-1:0] shots,
    input  logic               dcm_ready,
    input  logic               trig_ack,
    output logic [PHASE_W-1:0] phase,
    output logic               trig_req,
    output logic [SHOTS_W-1:0] cur_shot,
    output logic               busy,
    output logic               done,
    output logic               ack_timeout
);

    typedef enum logic [2:0] {IDLE, LOAD, BLANK, SETTLE, FIRE, WAIT_LOW, NEXT, DONE} state_t;

    if (SETTLE_CYCLES < 4 || SETTLE_CYCLES > 255) begin : g_bad_settle
        $error("SETTLE_CYCLES out of range 4..255");
    end
    if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be at least 2");
    end

    state_t             state_reg, state_next;
    logic [PHASE_W-1:0] phase_reg, phase_next;
    logic [PHASE_W-1:0] min_reg, min_next;
    logic [PHASE_W-1:0] max_reg, max_next;
    logic [PHASE_W-1:0] step_reg, step_next;
    logic [SHOTS_W-1:0] shots_reg, shots_next;
    logic [SHOTS_W-1:0] cur_shot_reg, cur_shot_next;
    logic               trig_req_reg, trig_req_next;
    logic               busy_reg, busy_next;
    logic               done_reg, done_next;
    logic               blank_reg, blank_next;
    logic [7:0]         settle_reg, settle_next;
    logic [8:0]         settle_inc;
    logic [SHOTS_W:0]   shot_inc;
    logic [PHASE_W:0]   nxt;

`ifdef GLITCH_SWEEP_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TMO_W-1:0]   tmo_reg, tmo_next;
    logic               ack_timeout_reg, ack_timeout_next;
`endif

    assign settle_inc = {1'b0, settle_reg} + 9'd1;
    assign shot_inc   = {1'b0, cur_shot_reg} + (SHOTS_W+1)'(1);
    assign nxt        = {1'b0, phase_reg} + {1'b0, step_reg};

    always_comb begin
        state_next    = state_reg;
        phase_next    = phase_reg;
        min_next      = min_reg;
        max_next      = max_reg;
        step_next     = step_reg;
        shots_next    = shots_reg;
        cur_shot_next = cur_shot_reg;
        blank_next    = blank_reg;
        settle_next   = settle_reg;
        done_next     = (state_reg == DONE);
`ifdef GLITCH_SWEEP_TIMEOUT_EN
        tmo_next         = tmo_reg;
        ack_timeout_next = ack_timeout_reg;
`endif
        case (state_reg)
            IDLE: begin
                if (start && !busy_reg && !abort) begin
                    min_next      = phase_min;
                    max_next      = phase_max;
                    step_next     = (phase_step == '0) ? PHASE_W'(1) : phase_step;
                    shots_next    = shots;
                    cur_shot_next = '0;
`ifdef GLITCH_SWEEP_TIMEOUT_EN
                    ack_timeout_next = 1'b0;
`endif
                    state_next    = (phase_min > phase_max) ? DONE : LOAD;
                end
            end
            LOAD: begin
                phase_next = min_reg;
                blank_next = 1'b0;
                state_next = BLANK;
            end
            BLANK: begin
                if (blank_reg) begin
                    settle_next = '0;
                    state_next  = SETTLE;
                end else begin
                    blank_next = 1'b1;
                end
            end
            SETTLE: begin
                // Only an unbroken run of ready cycles counts; single-cycle pulses reset to zero.
                if (!dcm_ready) begin
                    settle_next = '0;
                end else if (settle_inc == 9'(SETTLE_CYCLES)) begin
                    state_next = (shots_reg == '0) ? NEXT : FIRE;
                end else begin
                    settle_next = settle_inc[7:0];
                end
            end
            FIRE: begin
                if (trig_ack) state_next = WAIT_LOW;
            end
            WAIT_LOW: begin
                if (!trig_ack) begin
                    if (shot_inc == {1'b0, shots_reg}) begin
                        cur_shot_next = '0;
                        state_next    = NEXT;
                    end else begin
                        cur_shot_next = shot_inc[SHOTS_W-1:0];
                        state_next    = FIRE;
                    end
                end
            end
            NEXT: begin
                // The extra bit catches wrap-around past the top of the phase range.
                if (nxt > {1'b0, max_reg}) begin
                    state_next = DONE;
                end else begin
                    phase_next = nxt[PHASE_W-1:0];
                    state_next = BLANK;
                end
            end
            DONE: state_next = IDLE;
            default: state_next = IDLE;
        endcase
`ifdef GLITCH_SWEEP_TIMEOUT_EN
        if (state_reg == FIRE || state_reg == WAIT_LOW) begin
            tmo_next = tmo_reg + TMO_W'(1);
            if (tmo_next == TMO_W'(TIMEOUT_CYCLES)) begin
                state_next       = DONE;
                cur_shot_next    = cur_shot_reg;
                ack_timeout_next = 1'b1;
            end
        end
        if (state_next == FIRE && state_reg != FIRE) tmo_next = '0;
`endif
        if (abort && state_reg != IDLE) begin
            state_next    = IDLE;
            phase_next    = phase_reg;
            cur_shot_next = cur_shot_reg;
            done_next     = 1'b0;
`ifdef GLITCH_SWEEP_TIMEOUT_EN
            ack_timeout_next = ack_timeout_reg;
`endif
        end
        trig_req_next = (state_next == FIRE);
        busy_next     = (state_next != IDLE) || done_next;
    end

    always_ff @(posedge clkin) begin
        if (rst) begin
            state_reg    <= IDLE;
            phase_reg    <= '0;
            min_reg      <= '0;
            max_reg      <= '0;
            step_reg     <= '0;
            shots_reg    <= '0;
            cur_shot_reg <= '0;
            trig_req_reg <= 1'b0;
            busy_reg     <= 1'b0;
            done_reg     <= 1'b0;
            blank_reg    <= 1'b0;
            settle_reg   <= '0;
        end else begin
            state_reg    <= state_next;
            phase_reg    <= phase_next;
            min_reg      <= min_next;
            max_reg      <= max_next;
            step_reg     <= step_next;
            shots_reg    <= shots_next;
            cur_shot_reg <= cur_shot_next;
            trig_req_reg <= trig_req_next;
            busy_reg     <= busy_next;
            done_reg     <= done_next;
            blank_reg    <= blank_next;
            settle_reg   <= settle_next;
        end
    end

`ifdef GLITCH_SWEEP_TIMEOUT_EN
    always_ff @(posedge clkin) begin
        if (rst) begin
            tmo_reg         <= '0;
            ack_timeout_reg <= 1'b0;
        end else begin
            tmo_reg         <= tmo_next;
            ack_timeout_reg <= ack_timeout_next;
        end
    end
    assign ack_timeout = ack_timeout_reg;
`else
    assign ack_timeout = 1'b0;
`endif

    assign phase    = phase_reg;
    assign trig_req = trig_req_reg;
    assign cur_shot = cur_shot_reg;
    assign busy     = busy_reg;
    assign done     = done_reg;

endmodule

// File: tb/tb_glitch_phase_sweep.sv
// Scoreboard bench for glitch_phase_sweep: directed sweeps push expected requests/done events,
// a monitor pops and compares them as the DUT presents them.
module tb_glitch_phase_sweep;

    logic       clkin, rst, start, abort, dcm_ready, trig_ack;
    logic [7:0] phase_min, phase_max, phase_step, shots;
    logic [7:0] phase, cur_shot;
    logic       trig_req, busy, done, ack_timeout;

    glitch_phase_sweep #(.PHASE_W(8), .SHOTS_W(8), .SETTLE_CYCLES(16), .TIMEOUT_CYCLES(64)) dut (
        .clkin(clkin), .rst(rst), .start(start), .abort(abort),
        .phase_min(phase_min), .phase_max(phase_max), .phase_step(phase_step), .shots(shots),
        .dcm_ready(dcm_ready), .trig_ack(trig_ack),
        .phase(phase), .trig_req(trig_req), .cur_shot(cur_shot),
        .busy(busy), .done(done), .ack_timeout(ack_timeout)
    );

    typedef struct packed {
        logic       is_done;
        logic [7:0] ph;
        logic [7:0] shot;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0, errors = 0;
    int   cyc = 0;
    int   req_count = 0, done_count = 0;
    int   last_req_cyc = 0, last_fall_cyc = 0, last_done_cyc = 0, start_cyc = 0;
    logic dcm_manual = 1'b0, manual_ready = 1'b1, ack_stuck = 1'b0;

    initial clkin = 1'b0;
    always #5 clkin = ~clkin;
    always @(posedge clkin) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push_req(input logic [7:0] ph, input logic [7:0] shot);
        exp_q.push_back('{1'b0, ph, shot});
    endtask

    task automatic push_done(input logic [7:0] ph);
        exp_q.push_back('{1'b1, ph, 8'd0});
    endtask

    // DCM wrapper model: after a phase change ready drops, pulses once mid-shift, then locks.
    initial begin
        logic [7:0] last_ph;
        int lock_cnt;
        last_ph = 8'd0; lock_cnt = 0; dcm_ready = 1'b1;
        forever begin
            @(posedge clkin); #2;
            if (phase !== last_ph) begin
                last_ph = phase;
                if (!dcm_manual) lock_cnt = 6;
            end
            if (dcm_manual) dcm_ready = manual_ready;
            else begin
                dcm_ready = (lock_cnt == 0) || (lock_cnt == 3);
                if (lock_cnt > 0) lock_cnt--;
            end
        end
    end

    // Injector model: ack three cycles into a request, held until the request drops.
    initial begin
        int dly;
        dly = 0; trig_ack = 1'b0;
        forever begin
            @(posedge clkin); #1;
            if (ack_stuck || !trig_req) begin
                trig_ack = 1'b0; dly = 0;
            end else if (!trig_ack) begin
                if (dly == 2) trig_ack = 1'b1;
                else dly++;
            end
        end
    end

    // Monitor: compare each request rise and done pulse against the scoreboard.
    initial begin
        logic prev_req;
        exp_t e;
        prev_req = 1'b0;
        forever begin
            @(posedge clkin); #2;
            if (rst) begin
                prev_req = 1'b0;
            end else begin
                if (trig_req && !prev_req) begin
                    req_count++;
                    last_req_cyc = cyc;
                    if (exp_q.size() == 0) chk("unexpected_req", 1, 0);
                    else begin
                        e = exp_q.pop_front();
                        chk("req_event_kind", 0, int'(e.is_done));
                        chk("req_phase", int'(phase), int'(e.ph));
                        chk("req_cur_shot", int'(cur_shot), int'(e.shot));
                    end
                end
                if (!trig_req && prev_req) last_fall_cyc = cyc;
                if (done) begin
                    done_count++;
                    last_done_cyc = cyc;
                    if (exp_q.size() == 0) chk("unexpected_done", 1, 0);
                    else begin
                        e = exp_q.pop_front();
                        chk("done_event_kind", 1, int'(e.is_done));
                        chk("done_phase", int'(phase), int'(e.ph));
                        chk("done_busy", int'(busy), 1);
                    end
                end
                prev_req = trig_req;
            end
        end
    end

    task automatic start_sweep(input logic [7:0] mn, input logic [7:0] mx,
                               input logic [7:0] st, input logic [7:0] sh);
        @(posedge clkin); #1;
        phase_min = mn; phase_max = mx; phase_step = st; shots = sh;
        start = 1'b1; start_cyc = cyc;
        @(posedge clkin); #1;
        start = 1'b0;
    endtask

    task automatic wait_reqs(input int n, input int budget);
        for (int i = 0; i < budget && req_count < n; i++) begin
            @(posedge clkin); #3;
        end
        chk("req_count_reached", req_count, n);
    endtask

    task automatic wait_done(input int n, input int budget);
        for (int i = 0; i < budget && done_count < n; i++) begin
            @(posedge clkin); #3;
        end
        chk("done_count_reached", done_count, n);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; abort = 1'b0;
        phase_min = 8'd0; phase_max = 8'd0; phase_step = 8'd0; shots = 8'd0;
        repeat (3) @(posedge clkin);
        #3;
        chk("rst_phase", int'(phase), 0);
        chk("rst_trig_req", int'(trig_req), 0);
        chk("rst_cur_shot", int'(cur_shot), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_ack_timeout", int'(ack_timeout), 0);
        rst = 1'b0;

        // Sweep 10..20 step 5, two shots each; a second start mid-sweep must be ignored.
        for (int p = 10; p <= 20; p += 5) begin
            push_req(8'(p), 8'd0);
            push_req(8'(p), 8'd1);
        end
        push_done(8'd20);
        start_sweep(8'd10, 8'd20, 8'd5, 8'd2);
        #2;
        chk("busy_after_start", int'(busy), 1);
        @(posedge clkin); #1;
        phase_min = 8'd0; phase_max = 8'd0; shots = 8'd0; start = 1'b1;
        @(posedge clkin); #1;
        start = 1'b0;
        wait_done(1, 3000);
        chk("sweep_a_reqs", req_count, 6);
        @(posedge clkin); #3;
        chk("busy_after_done", int'(busy), 0);
        chk("phase_held_after_done", int'(phase), 20);

        // 250..255 step 10: next point would carry past the top.
        push_req(8'd250, 8'd0);
        push_req(8'd250, 8'd1);
        push_done(8'd250);
        start_sweep(8'd250, 8'd255, 8'd10, 8'd2);
        wait_done(2, 2000);
        chk("sweep_b_reqs", req_count, 8);

        // Empty range: done two cycles after start, nothing fired, phase untouched.
        push_done(8'd250);
        start_sweep(8'd30, 8'd20, 8'd1, 8'd2);
        wait_done(3, 50);
        chk("empty_done_latency", last_done_cyc - start_cyc, 2);
        chk("empty_no_reqs", req_count, 8);
        chk("empty_phase", int'(phase), 250);

        // Ready pulsing 1-high/3-low must not count as settled.
        push_req(8'd40, 8'd0);
        push_done(8'd40);
        dcm_manual = 1'b1;
        begin
            int last_low;
            last_low = 0;
            for (int i = 0; i < 40; i++) begin
                @(posedge clkin); #1;
                manual_ready = (i % 4 == 0);
                if (!manual_ready) last_low = cyc;
                if (i == 0) begin
                    phase_min = 8'd40; phase_max = 8'd40; phase_step = 8'd1; shots = 8'd1;
                    start = 1'b1;
                end else start = 1'b0;
            end
            @(posedge clkin); #1;
            manual_ready = 1'b1;
            wait_reqs(9, 100);
            chk("settle_after_last_low", last_req_cyc - last_low, 17);
        end
        wait_done(4, 200);
        dcm_manual = 1'b0;

        // Ready stable: start to first request is 1+2+16+1 cycles.
        push_req(8'd40, 8'd0);
        push_done(8'd40);
        start_sweep(8'd40, 8'd40, 8'd0, 8'd1);
        wait_reqs(10, 100);
        chk("start_to_req_latency", last_req_cyc - start_cyc, 20);
        wait_done(5, 200);

        // Abort during FIRE at the second point.
        push_req(8'd10, 8'd0);
        push_req(8'd10, 8'd1);
        push_req(8'd15, 8'd0);
        start_sweep(8'd10, 8'd20, 8'd5, 8'd2);
        wait_reqs(13, 500);
        abort = 1'b1;
        @(posedge clkin); #3;
        abort = 1'b0;
        chk("abort_req_low", int'(trig_req), 0);
        chk("abort_busy_low", int'(busy), 0);
        chk("abort_phase_hold", int'(phase), 15);
        repeat (10) @(posedge clkin);
        #3;
        chk("abort_no_done", done_count, 5);
        chk("abort_queue_empty", exp_q.size(), 0);

        // start and abort together in IDLE: stays idle.
        @(posedge clkin); #1;
        phase_min = 8'd10; phase_max = 8'd20; phase_step = 8'd5; shots = 8'd1;
        start = 1'b1; abort = 1'b1;
        @(posedge clkin); #1;
        start = 1'b0; abort = 1'b0;
        #2;
        chk("start_abort_busy", int'(busy), 0);
        repeat (40) @(posedge clkin);
        #3;
        chk("start_abort_no_reqs", req_count, 13);

`ifdef GLITCH_SWEEP_TIMEOUT_EN
        push_req(8'd40, 8'd0);
        push_done(8'd40);
        ack_stuck = 1'b1;
        start_sweep(8'd40, 8'd40, 8'd1, 8'd1);
        wait_reqs(14, 200);
        wait_done(6, 200);
        chk("timeout_req_width", last_fall_cyc - last_req_cyc, 64);
        chk("timeout_flag_set", int'(ack_timeout), 1);
        ack_stuck = 1'b0;
        push_req(8'd40, 8'd0);
        push_done(8'd40);
        start_sweep(8'd40, 8'd40, 8'd1, 8'd1);
        #2;
        chk("timeout_flag_cleared", int'(ack_timeout), 0);
        wait_done(7, 200);
`else
        chk("ack_timeout_tied_low", int'(ack_timeout), 0);
`endif

        chk("scoreboard_empty", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
